// File: rtl/intram_arbiter.sv
// ---------------------------------------------------------------------------
// intram_arbiter
//
// Two-requester arbiter and sequencer for the 2K x 8 single-port internal
// block RAM. Port 0 is the GbE receive writer side and port 1 is the LCD
// readout side; either port may read or write. Arbitration is round-robin
// with an optional burst lock that is forcibly released after LOCK_MAX beats.
//
// Optional feature macro: INTRAM_ARB_STATS_EN
//   When defined, adds saturating beat counters per port (p0_cnt, p1_cnt)
//   and a stall counter (stall_cnt). Arbitration is identical either way.
//
// Ports:
//   clk, reset_n              system clock, synchronous active-low reset
//   pX_req/we/lock/addr/wdata requester X beat request, write flag,
//                             keep-ownership flag, address, write data
//   pX_gnt                    requester X beat accepted this cycle
//   pX_rvalid, pX_rdata       registered read-return strobe and data
//   ram_ce, ram_oce, ram_wre  RAM clock enable, output enable (tied 1),
//                             write enable
//   ram_reset                 RAM output register reset (= ~reset_n)
//   ram_ad, ram_din           RAM address and write data
//   ram_dout                  RAM read data, valid one cycle after access
//   p0_cnt, p1_cnt, stall_cnt statistics (INTRAM_ARB_STATS_EN only)
// ---------------------------------------------------------------------------
module intram_arbiter #(
    parameter int AW       = 11,
    parameter int DW       = 8,
    parameter int LOCK_MAX = 64
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          p0_req,
    input  logic          p0_we,
    input  logic          p0_lock,
    input  logic [AW-1:0] p0_addr,
    input  logic [DW-1:0] p0_wdata,
    output logic          p0_gnt,
    output logic          p0_rvalid,
    output logic [DW-1:0] p0_rdata,
    input  logic          p1_req,
    input  logic          p1_we,
    input  logic          p1_lock,
    input  logic [AW-1:0] p1_addr,
    input  logic [DW-1:0] p1_wdata,
    output logic          p1_gnt,
    output logic          p1_rvalid,
    output logic [DW-1:0] p1_rdata,
    output logic          ram_ce,
    output logic          ram_oce,
    output logic          ram_wre,
    output logic          ram_reset,
    output logic [AW-1:0] ram_ad,
    output logic [DW-1:0] ram_din,
    input  logic [DW-1:0] ram_dout
`ifdef INTRAM_ARB_STATS_EN
    ,
    output logic [15:0]   p0_cnt,
    output logic [15:0]   p1_cnt,
    output logic [15:0]   stall_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    localparam logic [7:0] LOCK_MAX_C = 8'(LOCK_MAX);

    state_t     state;
    logic       last_winner;
    logic [7:0] lock_cnt;
    logic [7:0] lock_cnt_inc;
    logic       rvalid0_q;
    logic       rvalid1_q;
    logic       gnt0;
    logic       gnt1;
    logic       acc0;
    logic       acc1;

    // Grant decision. Grants are combinational from the requests and the
    // registered state so a beat can be accepted every cycle. While reset is
    // asserted nothing is granted. In IDLE a contested cycle goes to the
    // port that did not win the last accepted beat; in OWNx only the owner
    // can be granted, so the other port waits even if it is requesting.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (reset_n) begin
            case (state)
                IDLE: begin
                    if (p0_req && p1_req) begin
                        gnt0 = last_winner;
                        gnt1 = ~last_winner;
                    end else begin
                        gnt0 = p0_req;
                        gnt1 = p1_req;
                    end
                end
                OWN0:    gnt0 = p0_req;
                OWN1:    gnt1 = p1_req;
                default: ;
            endcase
        end
    end

    assign acc0         = p0_req & gnt0;
    assign acc1         = p1_req & gnt1;
    assign lock_cnt_inc = lock_cnt + 8'd1;

    // Arbitration FSM, lock counter, last-winner tracking and the read
    // return tags. Any release back to IDLE happens at the end of the cycle,
    // so a port waiting behind a lock is granted on the following cycle.
    // On a forced release last_winner already names the owner (it just won
    // a beat), which hands the next contested cycle to the other port.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= IDLE;
            lock_cnt    <= 8'd0;
            last_winner <= 1'b1;
            rvalid0_q   <= 1'b0;
            rvalid1_q   <= 1'b0;
        end else begin
            rvalid0_q <= acc0 & ~p0_we;
            rvalid1_q <= acc1 & ~p1_we;

            if (acc0) begin
                last_winner <= 1'b0;
            end else if (acc1) begin
                last_winner <= 1'b1;
            end

            case (state)
                IDLE: begin
                    // A single-beat lock limit means the first locked beat
                    // already exhausts it, so ownership is never taken.
                    if (LOCK_MAX_C > 8'd1) begin
                        if (acc0 && p0_lock) begin
                            state    <= OWN0;
                            lock_cnt <= 8'd1;
                        end else if (acc1 && p1_lock) begin
                            state    <= OWN1;
                            lock_cnt <= 8'd1;
                        end
                    end
                end
                OWN0: begin
                    if (!p0_req) begin
                        state    <= IDLE;
                        lock_cnt <= 8'd0;
                    end else if (acc0) begin
                        if (!p0_lock || lock_cnt_inc >= LOCK_MAX_C) begin
                            state    <= IDLE;
                            lock_cnt <= 8'd0;
                        end else begin
                            lock_cnt <= lock_cnt_inc;
                        end
                    end
                end
                OWN1: begin
                    if (!p1_req) begin
                        state    <= IDLE;
                        lock_cnt <= 8'd0;
                    end else if (acc1) begin
                        if (!p1_lock || lock_cnt_inc >= LOCK_MAX_C) begin
                            state    <= IDLE;
                            lock_cnt <= 8'd0;
                        end else begin
                            lock_cnt <= lock_cnt_inc;
                        end
                    end
                end
                default: begin
                    state    <= IDLE;
                    lock_cnt <= 8'd0;
                end
            endcase
        end
    end

    // RAM-side mux. With no grant the port-0 address and data are presented
    // but the RAM is not enabled. Read data is shared by both ports and is
    // only meaningful while the matching rvalid is high; rvalid is masked by
    // reset so a read in flight when reset arrives never returns.
    assign p0_gnt    = gnt0;
    assign p1_gnt    = gnt1;
    assign ram_ce    = gnt0 | gnt1;
    assign ram_oce   = 1'b1;
    assign ram_wre   = (gnt0 & p0_we) | (gnt1 & p1_we);
    assign ram_reset = ~reset_n;
    assign ram_ad    = gnt1 ? p1_addr  : p0_addr;
    assign ram_din   = gnt1 ? p1_wdata : p0_wdata;
    assign p0_rvalid = rvalid0_q & reset_n;
    assign p1_rvalid = rvalid1_q & reset_n;
    assign p0_rdata  = ram_dout;
    assign p1_rdata  = ram_dout;

`ifdef INTRAM_ARB_STATS_EN
    logic stall_evt;

    assign stall_evt = (p0_req & ~gnt0) | (p1_req & ~gnt1);

    // Saturating statistics: accepted beats per port, and cycles in which at
    // least one requesting port was left without a grant.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            p0_cnt    <= 16'd0;
            p1_cnt    <= 16'd0;
            stall_cnt <= 16'd0;
        end else begin
            if (acc0 && p0_cnt != 16'hFFFF) begin
                p0_cnt <= p0_cnt + 16'd1;
            end
            if (acc1 && p1_cnt != 16'hFFFF) begin
                p1_cnt <= p1_cnt + 16'd1;
            end
            if (stall_evt && stall_cnt != 16'hFFFF) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
        end
    end
`endif

endmodule
